// File: rtl/prime_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | prime_seq_ctrl : trial-division primality sequencer (go/busy/done)       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module prime_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic [1:0]       alu_sel,
  output logic [WIDTH-1:0] divisor,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SUB   = 3'd3,
    ST_TEST  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0]       C_OP_TRANSMIT = 2'b00;
  localparam logic [1:0]       C_OP_ZERO     = 2'b01;
  localparam logic [1:0]       C_OP_SUB      = 2'b10;
  localparam logic [1:0]       C_OP_INC      = 2'b11;
  localparam logic [WIDTH-1:0] C_TWO         = WIDTH'(2);
  localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] n_reg_q,    n_reg_d;
  logic [WIDTH-1:0] div_reg_q,  div_reg_d;
  logic [WIDTH-1:0] rem_reg_q,  rem_reg_d;
  logic             is_prime_q, is_prime_d;
  logic [CNT_W-1:0] cyc_cnt_q,  cyc_cnt_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [1:0]       alu_sel_q,  alu_sel_d;

  // Next state and datapath updates; outputs are registered from the next state
  always_comb begin
    state_d    = state_q;
    n_reg_d    = n_reg_q;
    div_reg_d  = div_reg_q;
    rem_reg_d  = rem_reg_q;
    is_prime_d = is_prime_q;
    cyc_cnt_d  = cyc_cnt_q;

    if (state_q != ST_IDLE && cyc_cnt_q != C_CNT_MAX) begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          n_reg_d   = n;
          cyc_cnt_d = '0;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (n_reg_q < C_TWO) begin
          is_prime_d = 1'b0;
          state_d    = ST_DONE;
        end else begin
          div_reg_d = C_TWO;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (div_reg_q == n_reg_q) begin
          is_prime_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          rem_reg_d = n_reg_q;
          state_d   = ST_SUB;
        end
      end
      ST_SUB: begin
        if (rem_reg_q >= div_reg_q) begin
          rem_reg_d = rem_reg_q - div_reg_q;
        end else begin
          state_d = ST_TEST;
        end
      end
      ST_TEST: begin
        if (rem_reg_q == '0) begin
          is_prime_d = 1'b0;
          state_d    = ST_DONE;
        end else begin
          div_reg_d = div_reg_q + WIDTH'(1);
          state_d   = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    case (state_d)
      ST_CHECK: alu_sel_d = C_OP_ZERO;
      ST_SUB:   alu_sel_d = C_OP_SUB;
      ST_TEST:  alu_sel_d = C_OP_INC;
      default:  alu_sel_d = C_OP_TRANSMIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      n_reg_q    <= '0;
      div_reg_q  <= '0;
      rem_reg_q  <= '0;
      is_prime_q <= 1'b0;
      cyc_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      alu_sel_q  <= C_OP_TRANSMIT;
    end else begin
      state_q    <= state_d;
      n_reg_q    <= n_reg_d;
      div_reg_q  <= div_reg_d;
      rem_reg_q  <= rem_reg_d;
      is_prime_q <= is_prime_d;
      cyc_cnt_q  <= cyc_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      alu_sel_q  <= alu_sel_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign is_prime = is_prime_q;
  assign alu_sel  = alu_sel_q;
  assign divisor  = div_reg_q;
  assign cyc_cnt  = cyc_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prime_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_prime_seq_ctrl : self-checking bench for prime_seq_ctrl               |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_prime_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             go  = 1'b0;
  logic [WIDTH-1:0] n   = '0;
  logic             busy;
  logic             done;
  logic             is_prime;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] divisor;
  logic [CNT_W-1:0] cyc_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model state carried between runs: divisor register and held result
  int unsigned model_div   = 0;
  bit          model_prime = 1'b0;

  logic [1:0] seq_q[$];

  prime_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .is_prime (is_prime),
    .alu_sel  (alu_sel),
    .divisor  (divisor),
    .cyc_cnt  (cyc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Smallest divisor decides primality; latency sums the per-divisor cost
  function automatic void ref_model(input int unsigned nv, output bit prime,
                                    output int unsigned sdiv, output int unsigned lat);
    int unsigned p;
    if (nv < 2) begin
      prime = 1'b0;
      sdiv  = 0;
      lat   = 2;
      return;
    end
    p = nv;
    for (int unsigned d = 2; d < nv; d++) begin
      if (nv % d == 0) begin
        p = d;
        break;
      end
    end
    prime = (p == nv);
    lat   = 1;
    for (int unsigned d = 2; d < p; d++) lat += nv / d + 3;
    lat  += prime ? 1 : (nv / p + 3);
    lat  += 1;
    sdiv  = p;
  endfunction

  task automatic do_run(input logic [WIDTH-1:0] nv, input int unsigned budget,
                        output int unsigned lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    seq_q.delete();
    @(negedge clk);
    n  = nv;
    go = 1'b1;
    for (int unsigned k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) go = 1'b0;
      seq_q.push_back(alu_sel);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    go  = 1'b1;
    n   = 16'd7;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (is_prime !== 1'b0) begin errors++; $display("FAIL reset_is_prime: got %0b expected 0", is_prime); end
    checks++; if (alu_sel !== 2'b00) begin errors++; $display("FAIL reset_alu_sel: got %0b expected 00", alu_sel); end
    checks++; if (divisor !== '0)    begin errors++; $display("FAIL reset_divisor: got %0d expected 0", divisor); end
    checks++; if (cyc_cnt !== '0)    begin errors++; $display("FAIL reset_cyc_cnt: got %0d expected 0", cyc_cnt); end
    go  = 1'b0;
    rst = 1'b1;
    model_div   = 0;
    model_prime = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_sequence();
    int unsigned lat;
    bit          bok;
    logic [11:0] obs;
    int unsigned vals[2] = '{0, 1};
    foreach (vals[i]) begin
      do_run(WIDTH'(vals[i]), 10, lat, bok);
      checks++; if (lat != 2)            begin errors++; $display("FAIL small%0d_latency: got %0d expected 2", vals[i], lat); end
      checks++; if (is_prime !== 1'b0)   begin errors++; $display("FAIL small%0d_is_prime: got %0b expected 0", vals[i], is_prime); end
      checks++; if (divisor !== WIDTH'(model_div)) begin errors++; $display("FAIL small%0d_divisor: got %0d expected %0d", vals[i], divisor, model_div); end
      checks++; if (seq_q.size() == 0 || seq_q[0] !== 2'b01) begin errors++; $display("FAIL small%0d_alu_sel: got %0b expected 01", vals[i], (seq_q.size() > 0) ? seq_q[0] : 2'bxx); end
      @(negedge clk);
      checks++; if (cyc_cnt !== 32'd2)   begin errors++; $display("FAIL small%0d_cyc_cnt: got %0d expected 2", vals[i], cyc_cnt); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL small%0d_idle: got busy=%0b done=%0b expected 0/0", vals[i], busy, done); end
    end

    do_run(16'd2, 10, lat, bok);
    checks++; if (lat != 3)             begin errors++; $display("FAIL n2_latency: got %0d expected 3", lat); end
    checks++; if (is_prime !== 1'b1)    begin errors++; $display("FAIL n2_is_prime: got %0b expected 1", is_prime); end
    checks++; if (divisor !== 16'd2)    begin errors++; $display("FAIL n2_divisor: got %0d expected 2", divisor); end
    @(negedge clk);
    checks++; if (cyc_cnt !== 32'd3)    begin errors++; $display("FAIL n2_cyc_cnt: got %0d expected 3", cyc_cnt); end

    do_run(16'd4, 20, lat, bok);
    obs = '0;
    for (int i = 0; i < 6 && i < seq_q.size(); i++) obs[11-2*i -: 2] = seq_q[i];
    checks++; if (obs !== 12'b01_00_10_10_10_11) begin errors++; $display("FAIL n4_alu_seq: got %b expected 010010101011", obs); end
    checks++; if (lat != 7)             begin errors++; $display("FAIL n4_latency: got %0d expected 7", lat); end
    checks++; if (is_prime !== 1'b0)    begin errors++; $display("FAIL n4_is_prime: got %0b expected 0", is_prime); end
    checks++; if (divisor !== 16'd2)    begin errors++; $display("FAIL n4_divisor: got %0d expected 2", divisor); end
    checks++; if (!bok)                 begin errors++; $display("FAIL n4_busy: got low during run expected high"); end
    @(negedge clk);
    checks++; if (cyc_cnt !== 32'd7)    begin errors++; $display("FAIL n4_cyc_cnt: got %0d expected 7", cyc_cnt); end
    model_div   = 2;
    model_prime = 1'b0;
  endtask

  task automatic test_directed();
    int unsigned vals[4] = '{5, 9, 251, 65535};
    int unsigned lat, elat, ediv;
    bit          bok, eprime;
    foreach (vals[i]) begin
      ref_model(vals[i], eprime, ediv, elat);
      if (vals[i] < 2) ediv = model_div;
      do_run(WIDTH'(vals[i]), elat + 10, lat, bok);
      checks++; if (lat != elat)          begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", vals[i], lat, elat); end
      checks++; if (is_prime !== eprime)  begin errors++; $display("FAIL dir%0d_is_prime: got %0b expected %0b", vals[i], is_prime, eprime); end
      checks++; if (divisor !== WIDTH'(ediv)) begin errors++; $display("FAIL dir%0d_divisor: got %0d expected %0d", vals[i], divisor, ediv); end
      checks++; if (!bok)                 begin errors++; $display("FAIL dir%0d_busy: got low during run expected high", vals[i]); end
      @(negedge clk);
      checks++; if (cyc_cnt !== CNT_W'(elat)) begin errors++; $display("FAIL dir%0d_cyc_cnt: got %0d expected %0d", vals[i], cyc_cnt, elat); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || is_prime !== eprime) begin errors++; $display("FAIL dir%0d_after: got busy=%0b done=%0b prime=%0b expected 0/0/%0b", vals[i], busy, done, is_prime, eprime); end
      model_div   = ediv;
      model_prime = eprime;
    end
  endtask

  task automatic test_random();
    int unsigned nv, lat, elat, ediv;
    bit          bok, eprime;
    for (int it = 0; it < 10; it++) begin
      nv = $urandom_range(0, 180);
      ref_model(nv, eprime, ediv, elat);
      if (nv < 2) ediv = model_div;
      do_run(WIDTH'(nv), elat + 10, lat, bok);
      checks++; if (lat != elat)          begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", nv, lat, elat); end
      checks++; if (is_prime !== eprime)  begin errors++; $display("FAIL rnd%0d_is_prime: got %0b expected %0b", nv, is_prime, eprime); end
      checks++; if (divisor !== WIDTH'(ediv)) begin errors++; $display("FAIL rnd%0d_divisor: got %0d expected %0d", nv, divisor, ediv); end
      checks++; if (!bok)                 begin errors++; $display("FAIL rnd%0d_busy: got low during run expected high", nv); end
      @(negedge clk);
      checks++; if (cyc_cnt !== CNT_W'(elat)) begin errors++; $display("FAIL rnd%0d_cyc_cnt: got %0d expected %0d", nv, cyc_cnt, elat); end
      model_div   = ediv;
      model_prime = eprime;
    end
  endtask

  task automatic test_go_held();
    int unsigned done_cnt   = 0;
    int unsigned first_done = 0;
    int unsigned second_done = 0;
    bit          prime_stable = 1'b1;
    bit          tail_idle    = 1'b1;
    logic        busy17       = 1'bx;
    logic [CNT_W-1:0] cnt34   = '0;
    @(negedge clk);
    n  = 16'd5;
    go = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        else if (second_done == 0) second_done = k;
      end
      if (k == 17) busy17 = busy;
      if (k == 34) cnt34 = cyc_cnt;
      if (k >= 16 && is_prime !== 1'b1) prime_stable = 1'b0;
      if (k >= 34 && busy !== 1'b0) tail_idle = 1'b0;
      if (k == 20) go = 1'b0;
    end
    checks++; if (first_done != 16)  begin errors++; $display("FAIL held_first_done: got cycle %0d expected 16", first_done); end
    checks++; if (busy17 !== 1'b0)   begin errors++; $display("FAIL held_idle_gap: got busy=%0b expected 0", busy17); end
    checks++; if (second_done != 33) begin errors++; $display("FAIL held_second_done: got cycle %0d expected 33", second_done); end
    checks++; if (done_cnt != 2)     begin errors++; $display("FAIL held_done_count: got %0d expected 2", done_cnt); end
    checks++; if (!prime_stable)     begin errors++; $display("FAIL held_prime_stable: got a drop expected steady 1"); end
    checks++; if (!tail_idle)        begin errors++; $display("FAIL held_no_third_run: got busy expected idle"); end
    checks++; if (cnt34 !== 32'd16)  begin errors++; $display("FAIL held_cyc_cnt: got %0d expected 16", cnt34); end
    model_div   = 5;
    model_prime = 1'b1;
  endtask

  task automatic test_reset_midrun();
    int unsigned lat, elat, ediv;
    bit          bok, eprime;
    bit          no_done = 1'b1;
    @(negedge clk);
    n  = 16'd97;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (alu_sel !== 2'b10) begin errors++; $display("FAIL abort_in_sub: got alu_sel=%0b expected 10", alu_sel); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL abort_done: got %0b expected 0", done); end
    checks++; if (is_prime !== 1'b0) begin errors++; $display("FAIL abort_is_prime: got %0b expected 0", is_prime); end
    checks++; if (cyc_cnt !== '0)    begin errors++; $display("FAIL abort_cyc_cnt: got %0d expected 0", cyc_cnt); end
    checks++; if (divisor !== '0)    begin errors++; $display("FAIL abort_divisor: got %0d expected 0", divisor); end
    model_div   = 0;
    model_prime = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    checks++; if (!no_done) begin errors++; $display("FAIL abort_quiet: got activity after reset expected idle"); end

    ref_model(97, eprime, ediv, elat);
    do_run(16'd97, elat + 10, lat, bok);
    checks++; if (lat != elat)         begin errors++; $display("FAIL rerun97_latency: got %0d expected %0d", lat, elat); end
    checks++; if (is_prime !== eprime) begin errors++; $display("FAIL rerun97_is_prime: got %0b expected %0b", is_prime, eprime); end
    checks++; if (divisor !== WIDTH'(ediv)) begin errors++; $display("FAIL rerun97_divisor: got %0d expected %0d", divisor, ediv); end
    @(negedge clk);
    checks++; if (cyc_cnt !== CNT_W'(elat)) begin errors++; $display("FAIL rerun97_cyc_cnt: got %0d expected %0d", cyc_cnt, elat); end
  endtask

  initial begin
    test_reset();
    test_alu_sequence();
    test_directed();
    test_random();
    test_go_held();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
